// File: rtl/morse_pkg.sv
// morse_pkg
//   Shared definitions for the Morse receive path: the key-timer state
//   encoding and the default timing constants that the key timer and the
//   downstream decoder both build on.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    WGAP  = 2'd3
  } key_state_t;

  localparam int DEF_DEBOUNCE_CYCLES  = 4;
  localparam int DEF_UNIT_CYCLES      = 1000;
  localparam int DEF_DASH_UNITS       = 2;
  localparam int DEF_LETTER_GAP_UNITS = 3;
  localparam int DEF_WORD_GAP_UNITS   = 7;

endpackage

// File: rtl/morse_debounce.sv
// morse_debounce
//   Two-flop synchronizer followed by a stability counter. The output only
//   follows the synchronized input after it has differed from the output for
//   DEBOUNCE_CYCLES consecutive cycles; shorter excursions are dropped.
// Ports
//   Clock  in  1  sole clock, posedge
//   Reset  in  1  synchronous, active-high
//   in     in  1  raw asynchronous level
//   out    out 1  synchronized, debounced level
module morse_debounce
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic Clock,
  input  logic Reset,
  input  logic in,
  output logic out
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          key_m;
  logic          key_s;
  logic [CW-1:0] db_cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      key_m  <= 1'b0;
      key_s  <= 1'b0;
      out    <= 1'b0;
      db_cnt <= '0;
    end else begin
      key_m <= in;
      key_s <= key_m;
      // db_cnt holds how many cycles the mismatch has already lasted; the
      // change is accepted on the DEBOUNCE_CYCLES-th mismatching cycle.
      if (key_s != out) begin
        if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          out    <= key_s;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/morse_key_timer.sv
// morse_key_timer
//   Front end of the Morse receive path. Debounces the raw key, times key
//   presses and release gaps, and emits one-cycle symbol pulses (dot, dash)
//   and separator pulses (letter_end, word_end) for the decoder.
// Ports
//   Clock       in   1  sole clock, posedge
//   Reset       in   1  synchronous, active-high; aborts any press in flight
//   key         in   1  raw asynchronous key, 1 = pressed
//   key_db      out  1  debounced key level
//   dot         out  1  one-cycle pulse: a dot was keyed
//   dash        out  1  one-cycle pulse: a dash was keyed
//   letter_end  out  1  one-cycle pulse: letter gap reached after last symbol
//   word_end    out  1  one-cycle pulse: word gap reached after last symbol
module morse_key_timer
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int UNIT_CYCLES      = DEF_UNIT_CYCLES,
  parameter int DASH_UNITS       = DEF_DASH_UNITS,
  parameter int LETTER_GAP_UNITS = DEF_LETTER_GAP_UNITS,
  parameter int WORD_GAP_UNITS   = DEF_WORD_GAP_UNITS
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key,
  output logic key_db,
  output logic dot,
  output logic dash,
  output logic letter_end,
  output logic word_end
);

  localparam int DASH_T   = DASH_UNITS * UNIT_CYCLES;
  localparam int LETTER_T = LETTER_GAP_UNITS * UNIT_CYCLES;
  localparam int WORD_T   = WORD_GAP_UNITS * UNIT_CYCLES;
  localparam int TW       = $clog2(WORD_T + 1);

  localparam logic [TW-1:0] T_MAX = {TW{1'b1}};

  key_state_t    state, state_d;
  logic [TW-1:0] t_cnt, t_d, t_inc;
  logic          dot_d, dash_d, letter_d, word_d;

  morse_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .Clock(Clock),
    .Reset(Reset),
    .in   (key),
    .out  (key_db)
  );

  assign t_inc = (t_cnt == T_MAX) ? t_cnt : t_cnt + 1'b1;

  // t_cnt equals the number of cycles key_db has been high (PRESS) or the
  // number of cycles since key_db fell (GAP/WGAP). Gap pulses are decided one
  // count early so they are high on the very cycle t_cnt reaches the
  // threshold; a press seen on that pulse cycle is taken one cycle later.
  always_comb begin
    state_d  = state;
    t_d      = t_cnt;
    dot_d    = 1'b0;
    dash_d   = 1'b0;
    letter_d = 1'b0;
    word_d   = 1'b0;
    case (state)
      IDLE: begin
        if (key_db) begin
          state_d = PRESS;
          t_d     = TW'(1);
        end
      end
      PRESS: begin
        if (key_db) begin
          t_d = t_inc;
        end else begin
          if (t_cnt >= TW'(DASH_T)) dash_d = 1'b1;
          else                      dot_d  = 1'b1;
          state_d = GAP;
          t_d     = TW'(1);
        end
      end
      GAP: begin
        if (key_db) begin
          state_d = PRESS;
          t_d     = TW'(1);
        end else begin
          t_d = t_inc;
          if (t_cnt == TW'(LETTER_T - 1)) begin
            letter_d = 1'b1;
            state_d  = WGAP;
          end
        end
      end
      WGAP: begin
        if (key_db) begin
          state_d = PRESS;
          t_d     = TW'(1);
        end else begin
          t_d = t_inc;
          if (t_cnt == TW'(WORD_T - 1)) begin
            word_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered state, counter and pulse outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      t_cnt      <= '0;
      dot        <= 1'b0;
      dash       <= 1'b0;
      letter_end <= 1'b0;
      word_end   <= 1'b0;
    end else begin
      state      <= state_d;
      t_cnt      <= t_d;
      dot        <= dot_d;
      dash       <= dash_d;
      letter_end <= letter_d;
      word_end   <= word_d;
    end
  end

endmodule

// File: tb/tb_morse_key_timer.sv
module tb_morse_key_timer;

  logic Clock = 1'b0;
  logic Reset;
  logic key;
  logic key_db, dot, dash, letter_end, word_end;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Event log written only by the monitor.
  int dot_n = 0, dash_n = 0, le_n = 0, we_n = 0, kr_n = 0, viol = 0;
  int dot_c = -1, dash_c = -1, le_c = -1, we_c = -1, kr_c = -1;
  logic p_dot = 1'b0, p_dash = 1'b0, p_le = 1'b0, p_we = 1'b0, p_kdb = 1'b0;

  morse_key_timer #(
    .DEBOUNCE_CYCLES (3),
    .UNIT_CYCLES     (8),
    .DASH_UNITS      (2),
    .LETTER_GAP_UNITS(3),
    .WORD_GAP_UNITS  (7)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .key       (key),
    .key_db    (key_db),
    .dot       (dot),
    .dash      (dash),
    .letter_end(letter_end),
    .word_end  (word_end)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if ((32'(dot) + 32'(dash) + 32'(letter_end) + 32'(word_end)) > 1) viol = viol + 1;
    if ((dot && p_dot) || (dash && p_dash) || (letter_end && p_le) || (word_end && p_we))
      viol = viol + 1;
    if (dot)        begin dot_n  = dot_n + 1;  dot_c  = cyc; end
    if (dash)       begin dash_n = dash_n + 1; dash_c = cyc; end
    if (letter_end) begin le_n   = le_n + 1;   le_c   = cyc; end
    if (word_end)   begin we_n   = we_n + 1;   we_c   = cyc; end
    if (key_db && !p_kdb) begin kr_n = kr_n + 1; kr_c = cyc; end
    p_dot  = dot;
    p_dash = dash;
    p_le   = letter_end;
    p_we   = word_end;
    p_kdb  = key_db;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Press the key for len cycles; returns the cycle index at release.
  task automatic press(input int len, output int rel);
    key = 1'b1;
    step(len);
    key = 1'b0;
    rel = cyc;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    key   = 1'b0;
    step(3);
    total++; if (key_db !== 1'b0) begin bad++; $display("FAIL rst_key_db: got %b want 0", key_db); end
    total++; if (dot !== 1'b0) begin bad++; $display("FAIL rst_dot: got %b want 0", dot); end
    total++; if (dash !== 1'b0) begin bad++; $display("FAIL rst_dash: got %b want 0", dash); end
    total++; if (letter_end !== 1'b0) begin bad++; $display("FAIL rst_letter_end: got %b want 0", letter_end); end
    total++; if (word_end !== 1'b0) begin bad++; $display("FAIL rst_word_end: got %b want 0", word_end); end
    Reset = 1'b0;
    step(100);
    total++; if ((dot_n + dash_n + le_n + we_n) !== 0) begin bad++; $display("FAIL quiet_pulses: got %0d want 0", dot_n + dash_n + le_n + we_n); end
    total++; if (kr_n !== 0) begin bad++; $display("FAIL quiet_key_db: got %0d rises want 0", kr_n); end
  endtask

  task automatic test_dot_timing;
    int rel;
    int b_dot, b_dash, b_le, b_we, b_v;
    b_dot = dot_n; b_dash = dash_n; b_le = le_n; b_we = we_n; b_v = viol;
    press(10, rel);
    step(70);
    total++; if (dot_n - b_dot !== 1) begin bad++; $display("FAIL dot_count: got %0d want 1", dot_n - b_dot); end
    total++; if (dash_n - b_dash !== 0) begin bad++; $display("FAIL dot_no_dash: got %0d want 0", dash_n - b_dash); end
    total++; if (dot_c !== rel + 6) begin bad++; $display("FAIL dot_time: got %0d want %0d", dot_c, rel + 6); end
    total++; if (le_n - b_le !== 1) begin bad++; $display("FAIL dot_le_count: got %0d want 1", le_n - b_le); end
    total++; if (le_c !== rel + 29) begin bad++; $display("FAIL letter_time: got %0d want %0d", le_c, rel + 29); end
    total++; if (we_n - b_we !== 1) begin bad++; $display("FAIL dot_we_count: got %0d want 1", we_n - b_we); end
    total++; if (we_c !== rel + 61) begin bad++; $display("FAIL word_time: got %0d want %0d", we_c, rel + 61); end
    total++; if (viol - b_v !== 0) begin bad++; $display("FAIL dot_excl: got %0d violations want 0", viol - b_v); end
  endtask

  task automatic test_dash_boundary;
    int rel;
    int b_dot, b_dash;
    b_dot = dot_n; b_dash = dash_n;
    press(20, rel);
    step(70);
    total++; if (dash_n - b_dash !== 1) begin bad++; $display("FAIL len20_dash: got %0d want 1", dash_n - b_dash); end
    total++; if (dot_n - b_dot !== 0) begin bad++; $display("FAIL len20_dot: got %0d want 0", dot_n - b_dot); end
    total++; if (dash_c !== rel + 6) begin bad++; $display("FAIL len20_time: got %0d want %0d", dash_c, rel + 6); end
    b_dot = dot_n; b_dash = dash_n;
    press(15, rel);
    step(70);
    total++; if (dot_n - b_dot !== 1) begin bad++; $display("FAIL len15_dot: got %0d want 1", dot_n - b_dot); end
    total++; if (dash_n - b_dash !== 0) begin bad++; $display("FAIL len15_dash: got %0d want 0", dash_n - b_dash); end
    b_dot = dot_n; b_dash = dash_n;
    press(16, rel);
    step(70);
    total++; if (dash_n - b_dash !== 1) begin bad++; $display("FAIL len16_dash: got %0d want 1", dash_n - b_dash); end
    total++; if (dot_n - b_dot !== 0) begin bad++; $display("FAIL len16_dot: got %0d want 0", dot_n - b_dot); end
  endtask

  task automatic test_glitch;
    int rel;
    int b_all, b_kr, b_dot, b_dash;
    b_all = dot_n + dash_n + le_n + we_n; b_kr = kr_n;
    press(2, rel);
    step(30);
    total++; if (kr_n - b_kr !== 0) begin bad++; $display("FAIL glitch_key_db: got %0d rises want 0", kr_n - b_kr); end
    total++; if (dot_n + dash_n + le_n + we_n - b_all !== 0) begin bad++; $display("FAIL glitch_pulses: got %0d want 0", dot_n + dash_n + le_n + we_n - b_all); end
    b_dot = dot_n; b_dash = dash_n; b_kr = kr_n;
    key = 1'b1; step(9);
    key = 1'b0; step(1);
    key = 1'b1; step(10);
    key = 1'b0;
    step(70);
    total++; if (dash_n - b_dash !== 1) begin bad++; $display("FAIL dip_dash: got %0d want 1", dash_n - b_dash); end
    total++; if (dot_n - b_dot !== 0) begin bad++; $display("FAIL dip_dot: got %0d want 0", dot_n - b_dot); end
    total++; if (kr_n - b_kr !== 1) begin bad++; $display("FAIL dip_key_db: got %0d rises want 1", kr_n - b_kr); end
  endtask

  task automatic test_back_to_back;
    int rel;
    int b_dot, b_dash, b_le, b_we, b_v;
    b_dot = dot_n; b_dash = dash_n; b_le = le_n; b_we = we_n; b_v = viol;
    press(4, rel);  step(10);
    press(20, rel); step(30);
    total++; if (le_n - b_le !== 1) begin bad++; $display("FAIL seq_mid_le: got %0d want 1", le_n - b_le); end
    total++; if (we_n - b_we !== 0) begin bad++; $display("FAIL seq_mid_we: got %0d want 0", we_n - b_we); end
    total++; if (le_c !== rel + 29) begin bad++; $display("FAIL seq_le_time: got %0d want %0d", le_c, rel + 29); end
    press(4, rel);
    step(70);
    total++; if (dot_n - b_dot !== 2) begin bad++; $display("FAIL seq_dots: got %0d want 2", dot_n - b_dot); end
    total++; if (dash_n - b_dash !== 1) begin bad++; $display("FAIL seq_dashes: got %0d want 1", dash_n - b_dash); end
    total++; if (le_n - b_le !== 2) begin bad++; $display("FAIL seq_le: got %0d want 2", le_n - b_le); end
    total++; if (we_n - b_we !== 1) begin bad++; $display("FAIL seq_we: got %0d want 1", we_n - b_we); end
    total++; if (we_c !== rel + 61) begin bad++; $display("FAIL seq_we_time: got %0d want %0d", we_c, rel + 61); end
    total++; if (viol - b_v !== 0) begin bad++; $display("FAIL seq_excl: got %0d violations want 0", viol - b_v); end
  endtask

  task automatic test_reset_midpress;
    int rel, er;
    int b_dot, b_dash;
    b_dot = dot_n; b_dash = dash_n;
    key = 1'b1;
    step(10);
    Reset = 1'b1;
    step(1);
    total++; if (key_db !== 1'b0) begin bad++; $display("FAIL midrst_key_db: got %b want 0", key_db); end
    step(1);
    Reset = 1'b0;
    er = cyc;
    step(12);
    key = 1'b0;
    rel = cyc;
    total++; if (kr_c !== er + 5) begin bad++; $display("FAIL midrst_rerise: got %0d want %0d", kr_c, er + 5); end
    step(70);
    total++; if (dot_n - b_dot !== 1) begin bad++; $display("FAIL midrst_dot: got %0d want 1", dot_n - b_dot); end
    total++; if (dash_n - b_dash !== 0) begin bad++; $display("FAIL midrst_dash: got %0d want 0", dash_n - b_dash); end
    total++; if (dot_c !== rel + 6) begin bad++; $display("FAIL midrst_time: got %0d want %0d", dot_c, rel + 6); end
  endtask

  task automatic test_long_press;
    int rel;
    int b_all, b_dash, b_v;
    b_all = dot_n + dash_n + le_n + we_n; b_dash = dash_n; b_v = viol;
    key = 1'b1;
    step(600);
    total++; if (dot_n + dash_n + le_n + we_n - b_all !== 0) begin bad++; $display("FAIL long_quiet: got %0d want 0", dot_n + dash_n + le_n + we_n - b_all); end
    key = 1'b0;
    rel = cyc;
    step(10);
    total++; if (dash_n - b_dash !== 1) begin bad++; $display("FAIL long_dash: got %0d want 1", dash_n - b_dash); end
    total++; if (dash_c !== rel + 6) begin bad++; $display("FAIL long_time: got %0d want %0d", dash_c, rel + 6); end
    step(70);
    total++; if (viol - b_v !== 0) begin bad++; $display("FAIL long_excl: got %0d violations want 0", viol - b_v); end
  endtask

  initial begin
    Reset = 1'b1;
    key   = 1'b0;
    test_reset;
    test_dot_timing;
    test_dash_boundary;
    test_glitch;
    test_back_to_back;
    test_reset_midpress;
    test_long_press;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
